token_rate_divider: RTL and testbench
=====================================

# token_rate_divider

Multi-channel serial token thinner. It generalises the fixed halve-by-two token filter to a runtime-programmable ratio 1:N. It has a keep-every-Nth or drop-every-Nth mode and per-channel phase clearing. It sits on single-bit token streams (one token = one cycle with input high) ahead of rate-limited consumers, and each channel is independent.

## Interface

**Parameters**
- CHANNELS, 4, number of independent token streams (≥1).
- CNT_W, 4, divisor and phase counter width (≥2); maximum N = 2^CNT_W − 1.

**Ports**
- clk, input, 1, single clock; all state on rising edge.
- rst, input, 1, asynchronous reset, active-low.
- a, input, CHANNELS, incoming tokens; bit i is channel i.
- b, output, CHANNELS, outgoing tokens; bit i is channel i.
- cfg_load, input, 1, one-cycle pulse that latches div and mode.
- div, input, CNT_W, requested divisor N; 0 is treated as 1.
- mode, input, 1, 0 = keep every Nth token, 1 = drop every Nth token.
- clr, input, CHANNELS, per-channel phase clear.
- phase, output, CHANNELS*CNT_W, current phase counter of each channel; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation

- **Config registers.** Holds div_q and mode_q. Reset values are div_q = 2 and mode_q = 0, so after reset every channel halves its stream.
- **Divisor.** Effective divisor N = (div_q == 0) ? 1 : div_q.
- **Per-channel state.** Each channel has a phase counter cnt[i] in the range 0..N−1. Its reset value is 0.
- **Output equation (combinational, same cycle as the token):**
  - mode_q = 0: b[i] = a[i] && (cnt[i] == N−1).
  - mode_q = 1: b[i] = a[i] && (cnt[i] != N−1).
- **Counter update (priority order):**
  1. cfg_load = 1: all cnt clear to 0.
  2. Otherwise, if clr[i] = 1: cnt[i] clears to 0.
  3. Otherwise, if a[i] = 1: cnt[i] becomes 0 if cnt[i] == N−1, else cnt[i] + 1.
  4. Otherwise cnt[i] holds.
- **Idle cycles.** Cycles with a[i] = 0 never advance the phase and never produce b[i] = 1.
- **N = 1.** Mode 0 passes every token; mode 1 passes none.
- **Phase output.** phase reflects the registered cnt values.

## Timing

- **Latency.** b has zero latency: it is a combinational function of a and registered state. It is valid in the same cycle as a.
- **Config change.**
  - cfg_load is sampled on the rising edge; div_q and mode_q take their new values after that edge.
  - A token arriving in the cfg_load cycle is judged with the old config and old cnt. Its phase advance is discarded because the counter clears.
  - The first token after the load is index 0 under the new config.
- **clr[i] together with a[i].** b[i] is judged on the current cnt[i]; the counter then clears, so clear wins over advance.
- **cfg_load together with clr.** Both clear the counters; the result is identical.
- **Divisor lowered by config.** Every cnt is 0 after the load, so no counter can exceed N−1. No out-of-range state is reachable.
- **Reset.**
  - While rst = 0, b is forced to all zeros and phase reads all zeros.
  - Asserting rst mid-stream clears cnt, div_q and mode_q immediately, without waiting for a clock edge.
  - Deassertion is expected synchronous to clk from upstream reset logic.
  - The first edge after release behaves as a normal cycle.
- **Per-cycle rate.** At most one token is accepted and emitted per channel per cycle. Back-to-back tokens are legal.

## Test plan

- **Reset default, halving.** Ch0 a = 110_011_101_000_1111 after reset → b = 010_001_001_000_0101. Other channels idle with b = 0.
- **Divide by 3, keep mode.** cfg_load with div = 3, mode = 0, then a = 1111111 on ch1 → b = 0010010. phase sequence is 0,1,2,0,1,2,0, ending at 1.
- **Divide by 3, drop mode.** Same stimulus as the previous case with mode = 1 → b = 1101101.
- **div = 0, both modes.** div = 0 with mode = 0, a = 1011 → b = 1011. Then div = 0 with mode = 1, same a → b = 0000.
- **Clear and config-load collisions.**
  - div = 4, mode = 0, ch2 a = 111 followed by a = 1 with clr[2] = 1: that token emits b = 1 (cnt was 3), then the phase reads 0.
  - A token in a cfg_load cycle is judged with the old div, and the next token is index 0.
- **Asynchronous reset mid-stream.** Pull rst low between clock edges while ch3 phase = 2 and div = 5 → phase and b go to 0 immediately. After release, ch3 a = 11 → b = 01 (default div 2, mode 0).

Source files
------------

// File: rtl/token_rate_divider.sv
// Multi-channel token thinner: passes (or drops) every Nth token per channel,
// with a runtime-programmable divisor and per-channel phase clear.
module token_rate_divider #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS-1:0]         a,
    output logic [CHANNELS-1:0]         b,
    input  logic                        cfg_load,
    input  logic [CNT_W-1:0]            div,
    input  logic                        mode,
    input  logic [CHANNELS-1:0]         clr,
    output logic [CHANNELS*CNT_W-1:0]   phase
);

    logic [CNT_W-1:0]    div_q, div_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CNT_W-1:0]    last_c;
    logic [CHANNELS-1:0] at_last_c;

    // Highest phase value (N-1); a divisor of 0 behaves as 1.
    always_comb begin
        last_c = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    end

    always_comb begin
        div_d     = div_q;
        mode_d    = mode_q;
        b         = '0;
        phase     = '0;
        at_last_c = '0;
        if (cfg_load) begin
            div_d  = div;
            mode_d = mode;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            at_last_c[i] = (cnt_q[i] == last_c);
            cnt_d[i]     = cnt_q[i];
            // A clear (global or local) beats the advance of a same-cycle token.
            if (cfg_load || clr[i]) begin
                cnt_d[i] = '0;
            end else if (a[i]) begin
                cnt_d[i] = at_last_c[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end
            b[i] = rst && a[i] && (at_last_c[i] ^ mode_q);
            phase[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= CNT_W'(2);
            mode_q <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            div_q  <= div_d;
            mode_q <= mode_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_token_rate_divider.sv
// Self-checking bench for token_rate_divider: directed vector table, async
// reset sequence, and randomized traffic against a token-index model.
module tb_token_rate_divider;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    a;
    logic [CH-1:0]    b;
    logic             cfg_load;
    logic [CW-1:0]    div;
    logic             mode;
    logic [CH-1:0]    clr;
    logic [CH*CW-1:0] phase;

    int checks = 0;
    int errors = 0;

    token_rate_divider #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .cfg_load (cfg_load),
        .div      (div),
        .mode     (mode),
        .clr      (clr),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] clr;
        logic       load;
        logic [3:0] div;
        logic       mode;
        logic [3:0] exp_b;
        int         ph_ch;
        logic [3:0] exp_ph;
    } vec_t;

    vec_t tbl[$];

    // Model: count tokens seen since the last clear; phase = count mod N.
    int m_idx [CH];
    int m_div;
    bit m_mode;

    function automatic int m_n();
        return (m_div == 0) ? 1 : m_div;
    endfunction

    function automatic logic [3:0] m_b(input logic [3:0] av);
        logic [3:0] r;
        int n;
        n = m_n();
        r = '0;
        for (int i = 0; i < CH; i++) begin
            r[i] = av[i] && (((m_idx[i] % n) == n - 1) != m_mode);
        end
        return r;
    endfunction

    function automatic logic [15:0] m_ph();
        logic [15:0] r;
        int n;
        n = m_n();
        r = '0;
        for (int i = 0; i < CH; i++) begin
            r[i*CW +: CW] = 4'(m_idx[i] % n);
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < CH; i++) m_idx[i] = 0;
        m_div  = 2;
        m_mode = 1'b0;
    endtask

    task automatic m_step(input logic [3:0] av, input logic [3:0] cv, input logic lv,
                          input logic [3:0] dv, input logic mv);
        if (lv) begin
            for (int i = 0; i < CH; i++) m_idx[i] = 0;
            m_div  = int'(dv);
            m_mode = mv;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (cv[i]) m_idx[i] = 0;
                else if (av[i]) m_idx[i] = m_idx[i] + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called just after a rising edge; returns outputs sampled mid-cycle.
    task automatic drive(input logic [3:0] av, input logic [3:0] cv, input logic lv,
                         input logic [3:0] dv, input logic mv,
                         output logic [3:0] b_s, output logic [15:0] ph_s);
        a = av; clr = cv; cfg_load = lv; div = dv; mode = mv;
        @(negedge clk);
        b_s  = b;
        ph_s = phase;
        @(posedge clk);
        m_step(av, cv, lv, dv, mv);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        a = '0; clr = '0; cfg_load = 1'b0; div = '0; mode = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic row(input logic [3:0] av, input logic [3:0] cv, input logic lv,
                       input logic [3:0] dv, input logic mv, input logic [3:0] eb,
                       input int pc, input logic [3:0] ep);
        vec_t v;
        v.a = av; v.clr = cv; v.load = lv; v.div = dv; v.mode = mv;
        v.exp_b = eb; v.ph_ch = pc; v.exp_ph = ep;
        tbl.push_back(v);
    endtask

    initial begin
        logic [3:0]  bs;
        logic [15:0] ps;
        logic [3:0]  t1_a [16];
        logic [3:0]  t1_b [16];
        logic [3:0]  t1_p [16];

        // Reset default: ch0 halving pattern.
        t1_a = '{1,1,0, 0,1,1, 1,0,1, 0,0,0, 1,1,1,1};
        t1_b = '{0,1,0, 0,0,1, 0,0,1, 0,0,0, 0,1,0,1};
        t1_p = '{0,1,0, 0,0,1, 0,1,1, 0,0,0, 0,1,0,1};
        for (int i = 0; i < 16; i++) row(t1_a[i], 4'h0, 1'b0, 4'h0, 1'b0, t1_b[i], 0, t1_p[i]);
        // Divide by 3, keep mode on ch1.
        row(4'h0, 4'h0, 1'b1, 4'd3, 1'b0, 4'h0, 0, 4'd0);
        for (int i = 0; i < 7; i++)
            row(4'h2, 4'h0, 1'b0, 4'h0, 1'b0, (i % 3 == 2) ? 4'h2 : 4'h0, 1, 4'(i % 3));
        row(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1, 4'd1);
        // Divide by 3, drop mode on ch1.
        row(4'h0, 4'h0, 1'b1, 4'd3, 1'b1, 4'h0, 1, 4'd1);
        for (int i = 0; i < 7; i++)
            row(4'h2, 4'h0, 1'b0, 4'h0, 1'b0, (i % 3 == 2) ? 4'h0 : 4'h2, 1, 4'(i % 3));
        // div = 0 in both modes on ch0.
        row(4'h0, 4'h0, 1'b1, 4'd0, 1'b0, 4'h0, 1, 4'd1);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h1, 0, 4'd0);
        row(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 4'd0);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h1, 0, 4'd0);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h1, 0, 4'd0);
        row(4'h0, 4'h0, 1'b1, 4'd0, 1'b1, 4'h0, 0, 4'd0);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 4'd0);
        row(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 4'd0);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 4'd0);
        row(4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 0, 4'd0);
        // div = 4 on ch2: clear together with a token at the last phase.
        row(4'h0, 4'h0, 1'b1, 4'd4, 1'b0, 4'h0, 0, 4'd0);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd0);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd1);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd2);
        row(4'h4, 4'h4, 1'b0, 4'h0, 1'b0, 4'h4, 2, 4'd3);
        row(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd0);
        // Token in the cfg_load cycle uses the old divisor; next token is index 0.
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd0);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd1);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd2);
        row(4'h4, 4'h0, 1'b1, 4'd2, 1'b0, 4'h4, 2, 4'd3);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd0);
        row(4'h4, 4'h0, 1'b0, 4'h0, 1'b0, 4'h4, 2, 4'd1);
        row(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 2, 4'd0);

        rst = 1'b0;
        a = 4'hF; clr = '0; cfg_load = 1'b0; div = '0; mode = 1'b0;
        #3;
        chk("reset_b", 32'(b), 32'h0);
        chk("reset_phase", 32'(phase), 32'h0);
        do_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].a, tbl[i].clr, tbl[i].load, tbl[i].div, tbl[i].mode, bs, ps);
            chk($sformatf("vec%0d_b", i), 32'(bs), 32'(tbl[i].exp_b));
            chk($sformatf("vec%0d_phase", i), 32'(ps[tbl[i].ph_ch*CW +: CW]), 32'(tbl[i].exp_ph));
            if (tbl[i].ph_ch != 3) chk($sformatf("vec%0d_ch3_idle", i), 32'(ps[15:12]), 32'h0);
        end

        // Asynchronous reset between edges with ch3 mid-stream at div 5.
        do_reset();
        drive(4'h0, 4'h0, 1'b1, 4'd5, 1'b0, bs, ps);
        drive(4'h8, 4'h0, 1'b0, 4'h0, 1'b0, bs, ps);
        drive(4'h8, 4'h0, 1'b0, 4'h0, 1'b0, bs, ps);
        chk("async_pre_phase", 32'(phase[15:12]), 32'd2);
        a = 4'h8;
        #2 rst = 1'b0;
        #1;
        chk("async_phase", 32'(phase), 32'h0);
        chk("async_b", 32'(b), 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        drive(4'h8, 4'h0, 1'b0, 4'h0, 1'b0, bs, ps);
        chk("post_rst_b0", 32'(bs), 32'h0);
        drive(4'h8, 4'h0, 1'b0, 4'h0, 1'b0, bs, ps);
        chk("post_rst_b1", 32'(bs), 32'h8);

        // Randomized traffic against the token-index model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [3:0]  av, cv, dv, eb;
            logic        lv, mv;
            logic [15:0] ep;
            av = 4'($urandom);
            if ($urandom_range(0, 3) == 0) av = av & 4'($urandom);
            for (int c = 0; c < CH; c++) cv[c] = ($urandom_range(0, 9) == 0);
            lv = ($urandom_range(0, 19) == 0);
            dv = 4'($urandom_range(0, 15));
            mv = 1'($urandom_range(0, 1));
            eb = m_b(av);
            ep = m_ph();
            drive(av, cv, lv, dv, mv, bs, ps);
            chk($sformatf("rand%0d_b", i), 32'(bs), 32'(eb));
            chk($sformatf("rand%0d_phase", i), 32'(ps), 32'(ep));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
